// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one SRAM-like bus between the IF (inst) and MEM (data)
// ports, tracks up to MAX_OUT outstanding requests and returns each response to
// the port that issued it, in acceptance order.
// Build option: define ARB_RR_EN for round-robin arbitration; otherwise data
// has fixed priority over inst.
module mem_port_arbiter #(
    parameter int MAX_OUT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);
    localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int DEPTH = 1 << PTR_W;
    localparam logic [2:0]       MAX_C  = 3'(MAX_OUT);
    localparam logic [PTR_W-1:0] LAST_P = PTR_W'(MAX_OUT - 1);

    // Owner encoding everywhere: 0 = inst, 1 = data.
    logic             lock_valid_q, lock_valid_d;
    logic             lock_owner_q, lock_owner_d;
    logic [DEPTH-1:0] fifo_q, fifo_d;
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [2:0]       count_q, count_d;

    logic grant, both_pick, accept, pop, head_owner;

    // Pointers wrap at MAX_OUT, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_P) ? '0 : p + PTR_W'(1);
    endfunction

`ifdef ARB_RR_EN
    logic rr_q, rr_d;
    assign both_pick = rr_q;
`else
    assign both_pick = 1'b1;
`endif

    // Grant: a held (locked) request keeps the bus; otherwise arbitrate among requesters.
    always_comb begin
        if (lock_valid_q)              grant = lock_owner_q;
        else if (inst_req && data_req) grant = both_pick;
        else                           grant = data_req;
    end

    // A full FIFO blocks new requests even if a pop happens this cycle (no bypass).
    assign bus_req   = (grant ? data_req : inst_req) & (count_q < MAX_C) & ~reset;
    assign bus_wr    = grant & data_wr;
    assign bus_wstrb = grant ? data_wstrb : 4'h0;
    assign bus_addr  = grant ? data_addr  : inst_addr;
    assign bus_wdata = grant ? data_wdata : 32'h0;

    assign accept       = bus_req & bus_addr_ok;
    assign inst_addr_ok = accept & ~grant;
    assign data_addr_ok = accept & grant;

    // A response with nothing outstanding is a slave protocol error and is dropped.
    assign pop          = bus_data_ok & (count_q != 3'd0) & ~reset;
    assign head_owner   = fifo_q[head_q];
    assign inst_data_ok = pop & ~head_owner;
    assign data_data_ok = pop & head_owner;
    assign inst_rdata   = inst_data_ok ? bus_rdata : 32'h0;
    assign data_rdata   = data_data_ok ? bus_rdata : 32'h0;

    // Next state for owner FIFO, lock and (optional) round-robin pointer.
    always_comb begin
        fifo_d       = fifo_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        lock_valid_d = lock_valid_q;
        lock_owner_d = lock_owner_q;
`ifdef ARB_RR_EN
        rr_d         = rr_q;
        if (accept) rr_d = ~grant;
`endif
        if (accept) begin
            fifo_d[tail_q] = grant;
            tail_d         = ptr_inc(tail_q);
        end
        if (pop) head_d = ptr_inc(head_q);
        case ({accept, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
        if (accept) begin
            lock_valid_d = 1'b0;
        end else if (bus_req) begin
            lock_valid_d = 1'b1;
            lock_owner_d = grant;
        end
    end

    // State registers; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            fifo_q       <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= 3'd0;
            lock_valid_q <= 1'b0;
            lock_owner_q <= 1'b0;
`ifdef ARB_RR_EN
            rr_q         <= 1'b0;
`endif
        end else begin
            fifo_q       <= fifo_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            lock_valid_q <= lock_valid_d;
            lock_owner_q <= lock_owner_d;
`ifdef ARB_RR_EN
            rr_q         <= rr_d;
`endif
        end
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single shared SRAM-like memory bus between the instruction-fetch port (IF stage) and the data port (MEM stage). It accepts up to `MAX_OUT` outstanding requests and records the owner of each accepted request in order. Read data and completion pulses go back to the owning port. It sits between the pipeline stages and the AXI/SRAM bridge.

## Interface
Parameters:
- `MAX_OUT`, 2: maximum accepted but not yet completed transactions (1..4).

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `inst_req` in 1: IF read request.
- `inst_addr` in 32: IF read address.
- `inst_addr_ok` out 1: IF request accepted this cycle.
- `inst_data_ok` out 1: IF read data valid this cycle.
- `inst_rdata` out 32: IF read data.
- `data_req` in 1: MEM request.
- `data_wr` in 1: 1 = write.
- `data_wstrb` in 4: byte strobes.
- `data_addr` in 32: MEM address.
- `data_wdata` in 32: MEM write data.
- `data_addr_ok` out 1: MEM request accepted.
- `data_data_ok` out 1: MEM response (read data, or write completion).
- `data_rdata` out 32: MEM read data.
- `bus_req` out 1: bus request.
- `bus_wr` out 1: bus write flag.
- `bus_wstrb` out 4: bus byte strobes.
- `bus_addr` out 32: bus address.
- `bus_wdata` out 32: bus write data.
- `bus_addr_ok` in 1: bus accepted the request.
- `bus_data_ok` in 1: bus response.
- `bus_rdata` in 32: bus read data.

## Operation
- State:
  - `lock_valid` / `lock_owner`: the held grant.
  - Owner FIFO, depth `MAX_OUT`, 1 bit per entry (0 = inst, 1 = data), with head pointer, tail pointer and `count`.
- Grant selection:
  - If `lock_valid`, the grant is `lock_owner`.
  - Otherwise use the arbitration policy (see Configuration).
  - Only requesting ports compete.
- Request path:
  - `bus_req` = granted port's req & (`count` < `MAX_OUT`) & ~`reset`.
  - `bus_addr`, `bus_wr`, `bus_wstrb` and `bus_wdata` mux from the granted port.
  - For an inst grant: `bus_wr`=0, `bus_wstrb`=0, `bus_wdata`=0.
- Accept = `bus_req` & `bus_addr_ok`. On accept:
  - Push the owner into the FIFO.
  - Pulse the granted port's `*_addr_ok`; the other port's `*_addr_ok` stays 0.
- Lock:
  - When `bus_req`=1 and `bus_addr_ok`=0, set `lock_valid` and `lock_owner` to the current grant. The bus request must stay stable until accepted.
  - Clear the lock on accept.
- Response path:
  - When `bus_data_ok`=1, pop the FIFO head.
  - Route the response to the head owner: pulse its `*_data_ok` and drive its `*_rdata` = `bus_rdata`.
  - The non-owner's `*_rdata` is 0.
- Boundaries:
  - Full (`count`=`MAX_OUT`): `bus_req`=0. A pop in the same cycle does not enable acceptance in that cycle; there is no bypass.
  - Empty: `bus_data_ok`=1 with `count`=0 is a protocol violation. It is ignored and no `*_data_ok` pulses.
  - Simultaneous push and pop: both happen and `count` is unchanged.
  - Pointers wrap modulo `MAX_OUT`.
- Reset, including mid-transaction:
  - Clears `lock_valid`, `lock_owner`, the pointers and `count`.
  - Responses pending at reset are dropped. The bus slave is reset in the same cycle.

## Timing
- Reset values:
  - `bus_req`, `inst_addr_ok`, `data_addr_ok`, `inst_data_ok` and `data_data_ok` are 0.
  - `inst_rdata` and `data_rdata` are 0.
  - `lock_valid`=0, `count`=0, round-robin pointer = inst.
- Grant, the `bus_*` request signals and `*_addr_ok` are combinational from the port inputs, `bus_addr_ok` and registered state. Added latency: 0 cycles.
- `*_data_ok` and `*_rdata` are combinational from `bus_data_ok`, `bus_rdata` and the FIFO head. Added latency: 0 cycles.
- FIFO, lock and round-robin state update on the `clk` edge after the event.
- Responses return in acceptance order.

## Configuration
- `ARB_RR_EN` defined: round-robin arbitration.
  - A 1-bit pointer marks the preferred port.
  - On every accept, the pointer moves to the port that was not granted.
  - When both ports request, the preferred port wins.
- `ARB_RR_EN` undefined: fixed priority, data > inst.
  - No pointer register exists.
  - Inst is granted only when `data_req`=0.
- Lock behaviour is identical in both modes.

## Test plan
- Single fetch: `inst_req`=1, `inst_addr`=0xbfc00000, `bus_addr_ok`=1 in cycle 0, `bus_data_ok`=1 with `bus_rdata`=0x3c1d8000 in cycle 2.
  - Expect `inst_addr_ok`=1 in cycle 0.
  - Expect `inst_data_ok`=1 and `inst_rdata`=0x3c1d8000 in cycle 2.
  - `data_*_ok` stays 0 throughout.
- Contention, `ARB_RR_EN` undefined: both ports request, `bus_addr_ok`=1.
  - Expect `bus_addr`=`data_addr` and `bus_wr`=`data_wr` for every cycle while `data_req`=1.
  - Inst is granted the first cycle `data_req` drops.
- Contention, `ARB_RR_EN` defined: both ports request continuously.
  - Expect grants inst, data, inst, data on consecutive accepts, starting from reset.
- Lock: `data_req`=1 with `bus_addr_ok`=0 for 3 cycles, and `inst_req` rises in cycle 1.
  - Expect the bus to stay on data through acceptance in cycle 3.
  - Inst is granted in cycle 4.
- Full / in-order, `MAX_OUT`=2: accept inst then data, with no `bus_data_ok`.
  - Expect `bus_req`=0 while a third request is pending.
  - First `bus_data_ok` routes to inst, second to data.
  - `bus_req` reasserts the cycle after the first pop.
- Reset mid-flight: reset with `count`=2.
  - Expect `count`=0 and `lock_valid`=0 next cycle.
  - A following `bus_data_ok` produces no `*_data_ok` pulse.
